// File: rtl/obi_rid_tracker.sv
// rtl/obi_rid_tracker.sv - OBI transaction-ID tracker: stores granted aids in order, returns them as rids.
module obi_rid_tracker #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int IDW   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s_req_i,
  input  logic [AW-1:0]            s_addr_i,
  input  logic                     s_we_i,
  input  logic [DW/8-1:0]          s_be_i,
  input  logic [DW-1:0]            s_wdata_i,
  input  logic [IDW-1:0]           s_aid_i,
  output logic                     s_gnt_o,
  output logic                     s_rvalid_o,
  output logic [DW-1:0]            s_rdata_o,
  output logic [IDW-1:0]           s_rid_o,
  output logic                     s_err_o,
  output logic                     m_req_o,
  output logic [AW-1:0]            m_addr_o,
  output logic                     m_we_o,
  output logic [DW/8-1:0]          m_be_o,
  output logic [DW-1:0]            m_wdata_o,
  input  logic                     m_gnt_i,
  input  logic                     m_rvalid_i,
  input  logic [DW-1:0]            m_rdata_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     proto_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [IDW-1:0] fifo_q [DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [PW:0]    occ_q, occ_d;
  logic           proto_err_q;
  logic           full, empty, push, pop;

  // full is gated by reset so grant follows its equation with full = 0 while in reset
  assign full  = ~rst_i & (occ_q == DEPTH_C);
  assign empty = (occ_q == '0);

  assign m_req_o   = s_req_i & ~full;
  assign m_addr_o  = s_addr_i;
  assign m_we_o    = s_we_i;
  assign m_be_o    = s_be_i;
  assign m_wdata_o = s_wdata_i;
  assign s_gnt_o   = m_gnt_i & ~full;

  assign push = s_req_i & s_gnt_o & ~rst_i;
  assign pop  = m_rvalid_i & ~empty;

  assign s_rvalid_o  = m_rvalid_i;
  assign s_rdata_o   = m_rdata_i;
  assign s_rid_o     = empty ? '0 : fifo_q[rptr_q];
  assign s_err_o     = m_rvalid_i & empty;
  assign occupancy_o = occ_q;
  assign proto_err_o = proto_err_q;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= s_aid_i;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      occ_q <= occ_d;
      // a response with nothing outstanding is a downstream protocol violation
      if (m_rvalid_i & empty) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_rid_tracker.sv
// tb/tb_obi_rid_tracker.sv - scoreboard bench for obi_rid_tracker.
module tb_obi_rid_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_req_i = 1'b0;
  logic [31:0] s_addr_i = '0;
  logic        s_we_i = 1'b0;
  logic [3:0]  s_be_i = '0;
  logic [31:0] s_wdata_i = '0;
  logic [3:0]  s_aid_i = '0;
  logic        s_gnt_o, s_rvalid_o, s_err_o;
  logic [31:0] s_rdata_o;
  logic [3:0]  s_rid_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o;
  logic        m_gnt_i = 1'b0;
  logic        m_rvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;
  logic [2:0]  occupancy_o;
  logic        proto_err_o;

  obi_rid_tracker dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_addr_i(s_addr_i), .s_we_i(s_we_i), .s_be_i(s_be_i),
    .s_wdata_i(s_wdata_i), .s_aid_i(s_aid_i), .s_gnt_o(s_gnt_o),
    .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o), .s_err_o(s_err_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .occupancy_o(occupancy_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;
  logic [3:0] exp_q [$];
  logic [3:0] exp_rid;
  int mocc = 0;

  // inputs change on the falling edge; outputs are compared 2 ns later
  task automatic do_cycle(input logic rst, input logic req, input logic [3:0] aid,
                          input logic gnt, input logic rv, input logic [31:0] rdata);
    @(negedge clk_i);
    rst_i = rst; s_req_i = req; s_aid_i = aid; m_gnt_i = gnt;
    m_rvalid_i = rv; m_rdata_i = rdata;
    s_addr_i = {aid, 28'h0000_100}; s_we_i = 1'b0; s_be_i = 4'hF; s_wdata_i = {8{aid}};
    #2;
  endtask

  task automatic test_reset;
    do_cycle(1, 1, 4'h5, 1, 0, 0);
    do_cycle(1, 1, 4'h5, 1, 0, 0);
    checks++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
    checks++; if (proto_err_o !== 1'b0) begin fails++; $display("FAIL reset_proto got=%b exp=0", proto_err_o); end
    checks++; if (s_gnt_o !== 1'b1 || m_req_o !== 1'b1) begin fails++; $display("FAIL reset_gnt got=%b/%b exp=1/1", s_gnt_o, m_req_o); end
    checks++; if (s_rid_o !== 4'd0) begin fails++; $display("FAIL reset_rid got=%h exp=0", s_rid_o); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL reset_nopush got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_single_read;
    do_cycle(0, 1, 4'h3, 1, 0, 0);
    checks++; if (s_gnt_o !== 1'b1) begin fails++; $display("FAIL single_gnt got=%b exp=1", s_gnt_o); end
    checks++; if (m_addr_o !== 32'h3000_0100) begin fails++; $display("FAIL single_addr got=%h exp=30000100", m_addr_o); end
    checks++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL single_occ0 got=%0d exp=0", occupancy_o); end
    exp_q.push_back(4'h3); mocc++;
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'(mocc)) begin fails++; $display("FAIL single_occ1 got=%0d exp=%0d", occupancy_o, mocc); end
    do_cycle(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    exp_rid = exp_q.pop_front(); mocc--;
    checks++; if (s_rvalid_o !== 1'b1 || s_rid_o !== exp_rid || s_rdata_o !== 32'hDEAD_BEEF || s_err_o !== 1'b0) begin
      fails++; $display("FAIL single_rsp got=%b/%h/%h/%b exp=1/%h/deadbeef/0", s_rvalid_o, s_rid_o, s_rdata_o, s_err_o, exp_rid);
    end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL single_occ2 got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_fill_and_full_pop;
    for (int i = 1; i <= 4; i++) begin
      do_cycle(0, 1, 4'(i), 1, 0, 0);
      checks++; if (s_gnt_o !== 1'b1) begin fails++; $display("FAIL fill_gnt%0d got=%b exp=1", i, s_gnt_o); end
      exp_q.push_back(4'(i)); mocc++;
    end
    do_cycle(0, 1, 4'h5, 1, 0, 0);
    checks++; if (s_gnt_o !== 1'b0 || m_req_o !== 1'b0) begin fails++; $display("FAIL full_block got=%b/%b exp=0/0", s_gnt_o, m_req_o); end
    checks++; if (occupancy_o !== 3'd4) begin fails++; $display("FAIL full_occ got=%0d exp=4", occupancy_o); end
    // response while full with a pending request: no grant this cycle
    do_cycle(0, 1, 4'h6, 1, 1, 32'h1111_0000);
    exp_rid = exp_q.pop_front(); mocc--;
    checks++; if (s_gnt_o !== 1'b0) begin fails++; $display("FAIL fullpop_gnt got=%b exp=0", s_gnt_o); end
    checks++; if (s_rid_o !== exp_rid || s_err_o !== 1'b0) begin fails++; $display("FAIL fullpop_rid got=%h/%b exp=%h/0", s_rid_o, s_err_o, exp_rid); end
    do_cycle(0, 1, 4'h6, 1, 0, 0);
    checks++; if (occupancy_o !== 3'd3) begin fails++; $display("FAIL fullpop_occ3 got=%0d exp=3", occupancy_o); end
    checks++; if (s_gnt_o !== 1'b1) begin fails++; $display("FAIL regrant got=%b exp=1", s_gnt_o); end
    exp_q.push_back(4'h6); mocc++;
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'd4) begin fails++; $display("FAIL fullpop_occ4 got=%0d exp=4", occupancy_o); end
    while (exp_q.size() > 0) begin
      do_cycle(0, 0, 0, 0, 1, 32'h2222_0000);
      exp_rid = exp_q.pop_front(); mocc--;
      checks++; if (s_rid_o !== exp_rid || s_rvalid_o !== 1'b1) begin fails++; $display("FAIL drain_rid got=%h exp=%h", s_rid_o, exp_rid); end
    end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL drain_occ got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] aid;
    do_cycle(0, 1, 4'h7, 1, 0, 0);
    exp_q.push_back(4'h7); mocc++;
    for (int i = 0; i < 20; i++) begin
      aid = 4'($urandom_range(0, 15));
      do_cycle(0, 1, aid, 1, 1, 32'(i));
      exp_rid = exp_q.pop_front();
      checks++; if (s_gnt_o !== 1'b1 || s_rid_o !== exp_rid || occupancy_o !== 3'(mocc)) begin
        fails++; $display("FAIL b2b_%0d got=%b/%h/%0d exp=1/%h/%0d", i, s_gnt_o, s_rid_o, occupancy_o, exp_rid, mocc);
      end
      exp_q.push_back(aid);
    end
    do_cycle(0, 0, 0, 0, 1, 0);
    exp_rid = exp_q.pop_front(); mocc--;
    checks++; if (s_rid_o !== exp_rid) begin fails++; $display("FAIL b2b_last got=%h exp=%h", s_rid_o, exp_rid); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL b2b_occ got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_unexpected;
    do_cycle(0, 0, 0, 0, 1, 32'hBAD0_0000);
    checks++; if (s_rvalid_o !== 1'b1 || s_err_o !== 1'b1 || s_rid_o !== 4'd0) begin
      fails++; $display("FAIL unexp_rsp got=%b/%b/%h exp=1/1/0", s_rvalid_o, s_err_o, s_rid_o);
    end
    do_cycle(0, 1, 4'h9, 1, 0, 0);
    checks++; if (proto_err_o !== 1'b1 || occupancy_o !== 3'd0) begin fails++; $display("FAIL unexp_flag got=%b/%0d exp=1/0", proto_err_o, occupancy_o); end
    exp_q.push_back(4'h9); mocc++;
    do_cycle(0, 0, 0, 0, 1, 32'h0000_0009);
    exp_rid = exp_q.pop_front(); mocc--;
    checks++; if (s_rid_o !== exp_rid || s_err_o !== 1'b0) begin fails++; $display("FAIL unexp_after got=%h/%b exp=%h/0", s_rid_o, s_err_o, exp_rid); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (proto_err_o !== 1'b1) begin fails++; $display("FAIL unexp_sticky got=%b exp=1", proto_err_o); end
  endtask

  task automatic test_reset_mid;
    do_cycle(0, 1, 4'hA, 1, 0, 0);
    do_cycle(0, 1, 4'hB, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'd2) begin fails++; $display("FAIL mid_occ2 got=%0d exp=2", occupancy_o); end
    do_cycle(1, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (occupancy_o !== 3'd0 || proto_err_o !== 1'b0) begin fails++; $display("FAIL mid_reset got=%0d/%b exp=0/0", occupancy_o, proto_err_o); end
    do_cycle(0, 0, 0, 0, 1, 32'hAAAA_AAAA);
    checks++; if (s_err_o !== 1'b1 || s_rid_o !== 4'd0) begin fails++; $display("FAIL mid_stale got=%b/%h exp=1/0", s_err_o, s_rid_o); end
    do_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (proto_err_o !== 1'b1) begin fails++; $display("FAIL mid_proto got=%b exp=1", proto_err_o); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_fill_and_full_pop;
    test_back_to_back;
    test_unexpected;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
